// File: rtl/exp6_pkg.sv
// Shared definitions for the sequence playback unit of the memory game.
// Holds the playback state encodings, which double as the codes shown on
// the 7-segment debug display, the code shown for an unknown state, and a
// helper that sizes the playback timer.
package exp6_pkg;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    CONCLUI = 4'd5
  } estado_t;

  localparam logic [3:0] CODIGO_DESCONHECIDO = 4'hF;

  // Counter width able to hold 0..m-1, never narrower than one bit.
  function automatic int largura_contador(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Debug display code for a state; anything outside the known set shows F.
  function automatic logic [3:0] codigo_estado(input estado_t e);
    logic [3:0] codigo;
    case (e)
      OCIOSO:  codigo = 4'd0;
      CARREGA: codigo = 4'd1;
      ACENDE:  codigo = 4'd2;
      APAGA:   codigo = 4'd3;
      PROXIMO: codigo = 4'd4;
      CONCLUI: codigo = 4'd5;
      default: codigo = CODIGO_DESCONHECIDO;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/exp6_temporizador.sv
// Up-counter used to time the lit and blank phases of each element.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-high reset, clears the count
//   zera   - synchronous clear, has priority over conta
//   conta  - advance the count by one; wraps to 0 after M-1
//   fim_t  - high while the count equals M-1
//   valor  - current count, so the parent can compare against shorter
//            terminal values when a single timer serves both phases
module exp6_temporizador
  import exp6_pkg::*;
#(
  parameter int M = 1000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             zera,
  input  logic                             conta,
  output logic                             fim_t,
  output logic [largura_contador(M)-1:0]   valor
);

  localparam int W = largura_contador(M);
  localparam logic [W-1:0] TERMINAL = W'(M - 1);

  // Count register: clear has priority, otherwise advance and wrap at M-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= (valor == TERMINAL) ? '0 : valor + W'(1);
    end
  end

  assign fim_t = (valor == TERMINAL);

endmodule

// File: rtl/exp6_exibe_sequencia.sv
// Playback unit for the memory game: walks the sequence memory from
// address 0 up to limite, lighting each element on the LEDs for ON_CYCLES
// and then blanking for OFF_CYCLES, and pulses fim once at the end.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   iniciar      - start request, only looked at while idle
//   limite       - last address to show (inclusive)
//   dado_mem     - sequence memory read data for endereco
//   endereco     - sequence memory address (registered)
//   leds         - LED drive (registered, follows the state by one cycle)
//   exibindo     - high while playback is in progress
//   fim          - one-cycle done pulse (registered)
//   db_estado    - state code for the debug display
module exp6_exibe_sequencia
  import exp6_pkg::*;
#(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       fim,
  output logic [3:0] db_estado
);

  // One timer serves both phases, so it is sized for the longer one and
  // the shorter phase's terminal count is compared here.
  localparam int M_TEMP = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int W_TEMP = largura_contador(M_TEMP);
  localparam logic [W_TEMP-1:0] TERM_ON  = W_TEMP'(ON_CYCLES - 1);
  localparam logic [W_TEMP-1:0] TERM_OFF = W_TEMP'(OFF_CYCLES - 1);

  estado_t           estado;
  estado_t           proximo_estado;
  logic [3:0]        dado_latch;
  logic              temp_zera;
  logic              temp_conta;
  logic              temp_fim;
  logic [W_TEMP-1:0] temp_valor;
  logic              fim_on;
  logic              fim_off;

  exp6_temporizador #(
    .M(M_TEMP)
  ) u_temporizador (
    .clock (clock),
    .reset (reset),
    .zera  (temp_zera),
    .conta (temp_conta),
    .fim_t (temp_fim),
    .valor (temp_valor)
  );

  // The phase matching the timer size can use the timer's own terminal
  // flag; the other phase ends on its own shorter count.
  assign fim_on  = (ON_CYCLES == M_TEMP)  ? temp_fim : (temp_valor == TERM_ON);
  assign fim_off = (OFF_CYCLES == M_TEMP) ? temp_fim : (temp_valor == TERM_OFF);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo_estado;
    end
  end

  // Next-state logic and the combinational Moore outputs. The timer only
  // runs in the lit and blank phases and is cleared on each terminal count,
  // so every phase starts counting from zero.
  always_comb begin
    proximo_estado = estado;
    temp_conta     = 1'b0;
    temp_zera      = 1'b1;
    exibindo       = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          proximo_estado = CARREGA;
        end
      end
      CARREGA: begin
        exibindo       = 1'b1;
        proximo_estado = ACENDE;
      end
      ACENDE: begin
        exibindo   = 1'b1;
        temp_conta = 1'b1;
        temp_zera  = fim_on;
        if (fim_on) begin
          proximo_estado = APAGA;
        end
      end
      APAGA: begin
        exibindo   = 1'b1;
        temp_conta = 1'b1;
        temp_zera  = fim_off;
        if (fim_off) begin
          proximo_estado = (endereco == limite) ? CONCLUI : PROXIMO;
        end
      end
      PROXIMO: begin
        exibindo       = 1'b1;
        proximo_estado = CARREGA;
      end
      CONCLUI: begin
        proximo_estado = OCIOSO;
      end
      default: begin
        proximo_estado = OCIOSO;
      end
    endcase
  end

  assign db_estado = codigo_estado(estado);

  // Datapath registers. The element is captured as CARREGA ends; the LED
  // and done registers are loaded from the current state, so they show the
  // lit phase and the done pulse one cycle after the state enters them.
  // The address only moves forward in PROXIMO, so with limite=15 it stops
  // at 15 and is brought back to 0 through CONCLUI, never by wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco   <= 4'd0;
      dado_latch <= 4'd0;
      leds       <= 4'd0;
      fim        <= 1'b0;
    end else begin
      fim  <= (estado == CONCLUI);
      leds <= (estado == ACENDE) ? dado_latch : 4'd0;
      if (estado == CARREGA) begin
        dado_latch <= dado_mem;
      end
      case (estado)
        PROXIMO:         endereco <= endereco + 4'd1;
        OCIOSO, CONCLUI: endereco <= 4'd0;
        default:         endereco <= endereco;
      endcase
    end
  end

endmodule
